// File: rtl/psum_mem_arbiter.sv
// Shares one single-port psum SRAM between read and write requesters.
// Buffered writes forward to reads; optional stats under PSUM_ARB_STATS_EN.
module psum_mem_arbiter #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int DATA_WIDTH         = 32,
    parameter int WBUF_DEPTH         = 2
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          rd_req,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] rd_addr,
    output logic                          rd_gnt,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_data_valid,
    input  logic                          wr_req,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_gnt,
    input  logic                          flush,
    output logic                          flush_done,
    output logic                          sram_ce,
    output logic                          sram_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_wdata,
    input  logic [DATA_WIDTH-1:0]         sram_rdata,
    output logic [31:0]                   stat_rd_stall,
    output logic [31:0]                   stat_fwd
);

    localparam int AW = LOG2_OF_MEM_HEIGHT;
    localparam int CW = $clog2(WBUF_DEPTH + 1);
    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

    typedef enum logic [1:0] {NORMAL, FLUSH, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [AW-1:0]         r_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [WBUF_DEPTH];
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr;
    logic [CW-1:0]         r_count;
    logic                  r_rd_sram;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_fwd_data;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sram_rd;
    logic                  w_fwd;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic [PW:0]           w_sum;
    logic [PW-1:0]         w_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full = (r_count == CW'(WBUF_DEPTH));
    assign wr_gnt = (r_state == NORMAL) && !w_full;
    assign w_push = wr_req && wr_gnt;

    // Youngest-match search: buffered entries oldest->youngest, then same-cycle write
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            w_sum = {1'b0, r_rptr} + (PW + 1)'(i);
            if (w_sum >= (PW + 1)'(WBUF_DEPTH))
                w_sum = w_sum - (PW + 1)'(WBUF_DEPTH);
            w_idx = w_sum[PW-1:0];
            if ((CW'(i) < r_count) && (r_addr[w_idx] == rd_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_idx];
            end
        end
        if (w_push && (wr_addr == rd_addr)) begin
            w_hit      = 1'b1;
            w_hit_data = wr_data;
        end
    end

    // SRAM slot arbitration and next-state selection
    always_comb begin
        rd_gnt    = 1'b0;
        w_pop     = 1'b0;
        w_sram_rd = 1'b0;
        w_fwd     = 1'b0;
        w_next    = r_state;
        case (r_state)
            NORMAL: begin
                if (w_full) begin
                    w_pop = 1'b1;
                end else if (rd_req) begin
                    rd_gnt    = 1'b1;
                    w_fwd     = w_hit;
                    w_sram_rd = !w_hit;
                end else if (r_count != '0) begin
                    w_pop = 1'b1;
                end
                if (flush)
                    w_next = FLUSH;
            end
            FLUSH: begin
                w_pop = (r_count != '0);
                if (r_count == '0)
                    w_next = DONE;
            end
            DONE: begin
                w_pop  = (r_count != '0);
                w_next = NORMAL;
            end
            default: w_next = NORMAL;
        endcase
    end

    assign sram_ce       = w_pop || w_sram_rd;
    assign sram_we       = w_pop;
    assign sram_addr     = w_sram_rd ? rd_addr : r_addr[r_rptr];
    assign sram_wdata    = r_data[r_rptr];
    assign flush_done    = (r_state == DONE);
    assign rd_data_valid = r_rd_valid;
    assign rd_data       = r_rd_sram ? sram_rdata : r_fwd_data;

    // Control state: FSM, FIFO pointers/count and read-return tracking
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_state    <= NORMAL;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_rd_sram  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= rd_gnt;
            r_rd_sram  <= w_sram_rd;
            if (w_fwd)
                r_fwd_data <= w_hit_data;
            if (w_push)
                r_wptr <= ptr_inc(r_wptr);
            if (w_pop)
                r_rptr <= ptr_inc(r_rptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Write-buffer storage; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= wr_addr;
            r_data[r_wptr] <= wr_data;
        end
    end

`ifdef PSUM_ARB_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;

    // Saturating stall and forward counters
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (rd_req && !rd_gnt && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_fwd && (r_fwd_cnt != '1))
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
        end
    end

    assign stat_rd_stall = r_stall_cnt;
    assign stat_fwd      = r_fwd_cnt;
`else
    assign stat_rd_stall = '0;
    assign stat_fwd      = '0;
`endif

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Directed-vector bench for psum_mem_arbiter (default parameters).
// Inputs change #1 after posedge; outputs are checked at negedge.
module tb_psum_mem_arbiter;

    logic        clk;
    logic        arst_n_in;
    logic        rd_req;
    logic [19:0] rd_addr;
    logic        rd_gnt;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt;
    logic        flush;
    logic        flush_done;
    logic        sram_ce;
    logic        sram_we;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] stat_rd_stall;
    logic [31:0] stat_fwd;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int sram_wr_cnt = 0;
    int wr_snap;
    logic [31:0] exp_stall;
    logic [31:0] exp_fwd;
    logic [31:0] mem [64];

    psum_mem_arbiter dut (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_gnt        (wr_gnt),
        .flush         (flush),
        .flush_done    (flush_done),
        .sram_ce       (sram_ce),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .stat_rd_stall (stat_rd_stall),
        .stat_fwd      (stat_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                mem[sram_addr[5:0]] <= sram_wdata;
                sram_wr_cnt <= sram_wr_cnt + 1;
            end else begin
                sram_rdata <= mem[sram_addr[5:0]];
            end
        end
    end

    always @(posedge clk) begin
        if (flush_done)
            fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic rr, input logic [19:0] ra,
                       input logic wq, input logic [19:0] wa,
                       input logic [31:0] wd, input logic fl);
        rd_req  = rr;
        rd_addr = ra;
        wr_req  = wq;
        wr_addr = wa;
        wr_data = wd;
        flush   = fl;
    endtask

    task automatic idle();
        drv(1'b0, 20'h0, 1'b0, 20'h0, 32'h0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef PSUM_ARB_STATS_EN
        chk({tag, "_stall"}, 64'(stat_rd_stall), 64'(exp_stall));
        chk({tag, "_fwd"}, 64'(stat_fwd), 64'(exp_fwd));
`else
        chk({tag, "_stall"}, 64'(stat_rd_stall), 64'd0);
        chk({tag, "_fwd"}, 64'(stat_fwd), 64'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'h0;
        mem[16] = 32'hAAAA;
        mem[8]  = 32'h88;
        mem[9]  = 32'h99;
        mem[3]  = 32'h33;
        sram_rdata = 32'h0;
        exp_stall = 0;
        exp_fwd   = 0;
        idle();
        arst_n_in = 1'b0;
        nxt();
        nxt();
        arst_n_in = 1'b1;

        // reset state
        mid();
        chk("rst_valid", 64'(rd_data_valid), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_fdone", 64'(flush_done), 64'd0);
        chk("rst_ce", 64'(sram_ce), 64'd0);
        chk("rst_wgnt", 64'(wr_gnt), 64'd1);
        chk_stats("rst");
        nxt();

        // plain SRAM read
        drv(1'b1, 20'h10, 1'b0, 20'h0, 32'h0, 1'b0);
        mid();
        chk("rd_gnt", 64'(rd_gnt), 64'd1);
        chk("rd_ce", 64'({sram_ce, sram_we}), 64'b10);
        chk("rd_addr", 64'(sram_addr), 64'h10);
        nxt();
        idle();
        mid();
        chk("rd_valid", 64'(rd_data_valid), 64'd1);
        chk("rd_data", 64'(rd_data), 64'hAAAA);
        nxt();
        mid();
        chk("rd_valid_off", 64'(rd_data_valid), 64'd0);
        nxt();

        // write then forwarded read
        drv(1'b0, 20'h0, 1'b1, 20'h5, 32'h1234, 1'b0);
        mid();
        chk("w5_gnt", 64'(wr_gnt), 64'd1);
        chk("w5_ce", 64'(sram_ce), 64'd0);
        nxt();
        drv(1'b1, 20'h5, 1'b0, 20'h0, 32'h0, 1'b0);
        mid();
        chk("f5_gnt", 64'(rd_gnt), 64'd1);
        chk("f5_no_sram", 64'(sram_ce), 64'd0);
        nxt();
        idle();
        exp_fwd = 1;
        mid();
        chk("f5_valid", 64'(rd_data_valid), 64'd1);
        chk("f5_data", 64'(rd_data), 64'h1234);
        chk("f5_drain", 64'({sram_ce, sram_we, sram_addr}), {2'b11, 20'h5});
        chk("f5_wdata", 64'(sram_wdata), 64'h1234);
        chk_stats("f5");
        nxt();

        // same-cycle write and read to one address
        drv(1'b1, 20'h7, 1'b1, 20'h7, 32'hBEEF, 1'b0);
        mid();
        chk("s7_gnts", 64'({rd_gnt, wr_gnt}), 64'b11);
        chk("s7_no_sram", 64'(sram_ce), 64'd0);
        nxt();
        idle();
        exp_fwd = 2;
        mid();
        chk("s7_data", 64'({rd_data_valid, rd_data}), {1'b1, 32'hBEEF});
        chk("s7_drain", 64'({sram_we, sram_addr}), {1'b1, 20'h7});
        chk_stats("s7");
        nxt();

        // fill buffer behind granted reads, then a stalled read
        drv(1'b1, 20'h8, 1'b1, 20'h1, 32'h111, 1'b0);
        mid();
        chk("fill0_gnt", 64'({rd_gnt, wr_gnt}), 64'b11);
        chk("fill0_sram", 64'({sram_ce, sram_we, sram_addr}), {2'b10, 20'h8});
        nxt();
        drv(1'b1, 20'h9, 1'b1, 20'h2, 32'h222, 1'b0);
        mid();
        chk("fill1_gnt", 64'({rd_gnt, wr_gnt}), 64'b11);
        chk("fill1_data", 64'(rd_data), 64'h88);
        nxt();
        drv(1'b1, 20'h3, 1'b0, 20'h0, 32'h0, 1'b0);
        mid();
        chk("stall_gnt", 64'({rd_gnt, wr_gnt}), 64'b00);
        chk("stall_drain", 64'({sram_ce, sram_we, sram_addr}), {2'b11, 20'h1});
        chk("stall_wdata", 64'(sram_wdata), 64'h111);
        chk("stall_prev", 64'({rd_data_valid, rd_data}), {1'b1, 32'h99});
        nxt();
        exp_stall = 1;
        mid();
        chk("unstall_gnt", 64'({rd_gnt, wr_gnt}), 64'b11);
        chk("unstall_sram", 64'({sram_ce, sram_we, sram_addr}), {2'b10, 20'h3});
        chk("unstall_noval", 64'(rd_data_valid), 64'd0);
        nxt();
        idle();
        mid();
        chk("unstall_data", 64'({rd_data_valid, rd_data}), {1'b1, 32'h33});
        chk("tail_drain", 64'({sram_we, sram_addr}), {1'b1, 20'h2});
        chk_stats("stall");
        nxt();

        // flush sequence
        drv(1'b0, 20'h0, 1'b1, 20'h1, 32'hD1, 1'b0);
        mid();
        chk("fl_w1_ce", 64'(sram_ce), 64'd0);
        nxt();
        drv(1'b0, 20'h0, 1'b1, 20'h2, 32'hD2, 1'b0);
        mid();
        chk("fl_w2_gnt", 64'(wr_gnt), 64'd1);
        chk("fl_drain1", 64'({sram_we, sram_addr, sram_wdata}), {1'b1, 20'h1, 32'hD1});
        nxt();
        drv(1'b0, 20'h0, 1'b0, 20'h0, 32'h0, 1'b1);
        mid();
        chk("fl_drain2", 64'({sram_we, sram_addr, sram_wdata}), {1'b1, 20'h2, 32'hD2});
        nxt();
        mid();
        chk("fl_state_f", 64'({wr_gnt, sram_ce, flush_done}), 64'b000);
        nxt();
        idle();
        mid();
        chk("fl_done", 64'({wr_gnt, flush_done}), 64'b01);
        nxt();
        mid();
        chk("fl_back", 64'({wr_gnt, flush_done}), 64'b10);
        nxt();
        chk("fl_pulses", 64'(fd_cnt), 64'd1);
        chk("fl_mem", 64'({mem[1], mem[2]}), {32'hD1, 32'hD2});

        // reset with a full buffer
        drv(1'b1, 20'h8, 1'b1, 20'h1, 32'h5A, 1'b0);
        nxt();
        drv(1'b1, 20'h9, 1'b1, 20'h2, 32'h5B, 1'b0);
        nxt();
        idle();
        arst_n_in = 1'b0;
        nxt();
        arst_n_in = 1'b1;
        wr_snap = sram_wr_cnt;
        mid();
        chk("r2_ce", 64'(sram_ce), 64'd0);
        chk("r2_outs", 64'({rd_data_valid, rd_data, flush_done}), 64'd0);
        chk("r2_wgnt", 64'(wr_gnt), 64'd1);
        exp_stall = 0;
        exp_fwd   = 0;
        chk_stats("r2");
        nxt();
        nxt();
        nxt();
        chk("r2_no_writes", 64'(sram_wr_cnt), 64'(wr_snap));
        chk("r2_mem2", 64'(mem[2]), 64'hD2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
